branch_dir_pred: RTL

BRANCH_DIR_PRED -- requirements
Module: branch_dir_pred

---
 rtl/branch_dir_pred_if.sv | 34 +++
 rtl/branch_dir_pred.sv | 98 +++++++++
 2 files changed

// File: rtl/branch_dir_pred_if.sv
// Fetch/resolve-side bundle for the branch direction predictor.
// master = pipeline driving fetch PC, BTB target and resolved outcomes; slave = predictor.
interface branch_dir_pred_if;
    logic [31:0] pc_out;
    logic [31:0] btb_out;
    logic        update_en;
    logic [31:0] idex_pc_value;
    logic        br_taken;
    logic        ready;
    logic        predict_taken;
    logic [31:0] pred_pc;

    modport master (
        output pc_out,
        output btb_out,
        output update_en,
        output idex_pc_value,
        output br_taken,
        input  ready,
        input  predict_taken,
        input  pred_pc
    );

    modport slave (
        input  pc_out,
        input  btb_out,
        input  update_en,
        input  idex_pc_value,
        input  br_taken,
        output ready,
        output predict_taken,
        output pred_pc
    );
endinterface

// File: rtl/branch_dir_pred.sv
// Bimodal 2-bit-counter direction predictor; 1-cycle read latency aligned with btb_out.
// No backpressure: table is swept to weak-NT after reset, updates ignored until ready.
module branch_dir_pred #(
    parameter int S_INDEX = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    branch_dir_pred_if.slave  bus
);
    localparam int DEPTH = 1 << S_INDEX;
    localparam logic [S_INDEX-1:0] PTR_LAST = '1;
    localparam logic [S_INDEX-1:0] PTR_ONE  = S_INDEX'(1);
    localparam logic [1:0]         CTR_WNT  = 2'b01;

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t             state_q, state_d;
    logic [S_INDEX-1:0] ptr_q, ptr_d;
    logic [31:0]        pc_q;
    logic [1:0]         ctr_q;

    logic [1:0]         tbl [DEPTH];

    logic [S_INDEX-1:0] rd_idx;
    logic [S_INDEX-1:0] upd_idx;
    logic [S_INDEX-1:0] wr_idx;
    logic               wr_en;
    logic [1:0]         wr_val;
    logic [1:0]         upd_old;
    logic [1:0]         upd_new;
    logic [1:0]         rd_val;
    logic               unused_idex_hi;

    assign rd_idx         = bus.pc_out[S_INDEX-1:0];
    assign upd_idx        = bus.idex_pc_value[S_INDEX-1:0];
    assign upd_old        = tbl[upd_idx];
    assign unused_idex_hi = ^bus.idex_pc_value[31:S_INDEX];

    always_comb begin
        upd_new = upd_old;
        if (bus.br_taken) begin
            if (upd_old != 2'b11) upd_new = upd_old + 2'b01;
        end else begin
            if (upd_old != 2'b00) upd_new = upd_old - 2'b01;
        end
    end

    // Single write port shared by the init sweep and branch resolution.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        wr_en   = 1'b0;
        wr_idx  = upd_idx;
        wr_val  = upd_new;
        case (state_q)
            ST_INIT: begin
                wr_en  = 1'b1;
                wr_idx = ptr_q;
                wr_val = CTR_WNT;
                ptr_d  = ptr_q + PTR_ONE;
                if (ptr_q == PTR_LAST) state_d = ST_RUN;
            end
            ST_RUN: begin
                wr_en = bus.update_en;
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

    // Write-first: a same-cycle write to the read index is what gets captured.
    // Also covers the last sweep entry, so ctr_q is never stale when ready rises.
    assign rd_val = (wr_en && (wr_idx == rd_idx)) ? wr_val : tbl[rd_idx];

    always_ff @(posedge clk) begin
        if (wr_en) tbl[wr_idx] <= wr_val;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_INIT;
            ptr_q   <= '0;
            pc_q    <= '0;
            ctr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            pc_q    <= bus.pc_out;
            ctr_q   <= rd_val;
        end
    end

    assign bus.ready         = (state_q == ST_RUN);
    assign bus.predict_taken = bus.ready & ctr_q[1];
    assign bus.pred_pc       = bus.predict_taken ? bus.btb_out : (pc_q + 32'd4);

endmodule
